// File: rtl/score_display_ctrl.sv
// Pong score keeper and score-digit sprite sequencer: tracks points, win state and
// post-point blinking, and drives the shared digit ROM for a two-stage pixel pipeline.
module score_display_ctrl #(
    parameter int LEFT_X       = 280,
    parameter int RIGHT_X      = 349,
    parameter int DIGIT_Y      = 20,
    parameter int DIGIT_W      = 11,
    parameter int DIGIT_H      = 16,
    parameter int WIN_SCORE    = 9,
    parameter int BLINK_FRAMES = 32,
    parameter int BLINK_SHIFT  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       point_left,
    input  logic       point_right,
    input  logic       clear,
    input  logic [9:0] pix_row,
    input  logic [9:0] pix_col,
    output logic [3:0] digit_sel,
    output logic [9:0] sprite_row,
    output logic [9:0] sprite_col,
    input  logic [2:0] sprite_rgb,
    output logic [2:0] rgb,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner
);

    localparam int CNT_W = ($clog2(BLINK_FRAMES) > BLINK_SHIFT + 1) ?
                           $clog2(BLINK_FRAMES) : BLINK_SHIFT + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [3:0] WIN  = 4'(WIN_SCORE);
    localparam logic [9:0] ROW0 = 10'(DIGIT_Y);
    localparam logic [9:0] ROW1 = 10'(DIGIT_Y + DIGIT_H - 1);
    localparam logic [9:0] LX0  = 10'(LEFT_X);
    localparam logic [9:0] LX1  = 10'(LEFT_X + DIGIT_W - 1);
    localparam logic [9:0] RX0  = 10'(RIGHT_X);
    localparam logic [9:0] RX1  = 10'(RIGHT_X + DIGIT_W - 1);

    typedef enum logic [1:0] {PLAY, BLINK, OVER} state_t;

    state_t           state, state_next;
    logic [3:0]       left_next, right_next;
    logic             winner_next;
    logic             blink_side, blink_side_next;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLAY;
            score_left  <= '0;
            score_right <= '0;
            winner      <= 1'b0;
            blink_side  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_next;
            score_left  <= left_next;
            score_right <= right_next;
            winner      <= winner_next;
            blink_side  <= blink_side_next;
            frame_cnt   <= frame_cnt_next;
        end
    end

    // A left point shadows a same-cycle right point; clear shadows both.
    always_comb begin
        state_next      = state;
        left_next       = score_left;
        right_next      = score_right;
        winner_next     = winner;
        blink_side_next = blink_side;
        frame_cnt_next  = frame_cnt;
        if (clear) begin
            state_next     = PLAY;
            left_next      = '0;
            right_next     = '0;
            winner_next    = 1'b0;
            frame_cnt_next = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (point_left) begin
                        left_next = (score_left < WIN) ? score_left + 4'd1 : score_left;
                        if (left_next == WIN) begin
                            state_next  = OVER;
                            winner_next = 1'b0;
                        end else begin
                            state_next      = BLINK;
                            blink_side_next = 1'b0;
                            frame_cnt_next  = '0;
                        end
                    end else if (point_right) begin
                        right_next = (score_right < WIN) ? score_right + 4'd1 : score_right;
                        if (right_next == WIN) begin
                            state_next  = OVER;
                            winner_next = 1'b1;
                        end else begin
                            state_next      = BLINK;
                            blink_side_next = 1'b1;
                            frame_cnt_next  = '0;
                        end
                    end
                end
                BLINK: begin
                    if (frame_tick) begin
                        if (frame_cnt == CNT_LAST) begin
                            state_next     = PLAY;
                            frame_cnt_next = '0;
                        end else begin
                            frame_cnt_next = frame_cnt + 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (frame_tick) frame_cnt_next = frame_cnt + 1'b1;
                end
                default: state_next = PLAY;
            endcase
        end
    end

    assign game_over = (state == OVER);

    logic [9:0] row_s1, col_s1;
    logic       row_in, hit_left, hit_right, hide_left, hide_right, show;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1 <= '0;
            col_s1 <= '0;
            rgb    <= '0;
        end else begin
            row_s1 <= pix_row;
            col_s1 <= pix_col;
            rgb    <= show ? sprite_rgb : 3'b000;
        end
    end

    assign row_in    = (row_s1 >= ROW0) && (row_s1 <= ROW1);
    assign hit_left  = row_in && (col_s1 >= LX0) && (col_s1 <= LX1);
    assign hit_right = row_in && (col_s1 >= RX0) && (col_s1 <= RX1);

    // The blinking side is the last scorer during BLINK and the winner during OVER.
    assign hide_left  = frame_cnt[BLINK_SHIFT] &&
                        (((state == BLINK) && !blink_side) || ((state == OVER) && !winner));
    assign hide_right = frame_cnt[BLINK_SHIFT] &&
                        (((state == BLINK) && blink_side) || ((state == OVER) && winner));
    assign show       = (hit_left && !hide_left) || (hit_right && !hide_right);

    always_comb begin
        digit_sel  = '0;
        sprite_row = '0;
        sprite_col = '0;
        if (hit_left) begin
            digit_sel  = score_left;
            sprite_row = row_s1 - ROW0;
            sprite_col = col_s1 - LX0;
        end else if (hit_right) begin
            digit_sel  = score_right;
            sprite_row = row_s1 - ROW0;
            sprite_col = col_s1 - RX0;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: directed scenarios plus random traffic,
// compared cycle by cycle against a behavioural score/blink model and a fake digit ROM.
module tb_score_display_ctrl;

    localparam int LEFT_X = 280, RIGHT_X = 349, DIGIT_Y = 20, DIGIT_W = 11, DIGIT_H = 16;
    localparam int WIN_SCORE = 9, BLINK_FRAMES = 32, BLINK_SHIFT = 3;

    logic       clk = 1'b0;
    logic       reset, frame_tick, point_left, point_right, clear;
    logic [9:0] pix_row, pix_col;
    logic [3:0] digit_sel;
    logic [9:0] sprite_row, sprite_col;
    logic [2:0] sprite_rgb, rgb;
    logic [3:0] score_left, score_right;
    logic       game_over, winner;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_display_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .point_left(point_left), .point_right(point_right), .clear(clear),
        .pix_row(pix_row), .pix_col(pix_col),
        .digit_sel(digit_sel), .sprite_row(sprite_row), .sprite_col(sprite_col),
        .sprite_rgb(sprite_rgb), .rgb(rgb),
        .score_left(score_left), .score_right(score_right),
        .game_over(game_over), .winner(winner)
    );

    // Stand-in digit ROM with a distinct pattern per digit, row and column.
    function automatic logic [2:0] rom_pixel(input logic [3:0] d, input logic [9:0] r,
                                             input logic [9:0] c);
        return 3'((int'(d) * 5 + int'(r) * 3 + int'(c) * 7 + 1) % 8);
    endfunction

    assign sprite_rgb = rom_pixel(digit_sel, sprite_row, sprite_col);

    int         m_left, m_right, m_winner, m_side, m_ticks;
    bit         m_over, m_blinking;
    logic [2:0] pending_rgb;

    function automatic bit side_hidden(input int side);
        bit blinking_here;
        blinking_here = (m_blinking && m_side == side) || (m_over && m_winner == side);
        return blinking_here && (((m_ticks >> BLINK_SHIFT) % 2) == 1);
    endfunction

    task automatic model_update(input bit fr, input bit pl, input bit pr, input bit cl,
                                input bit rs);
        if (rs || cl) begin
            m_left = 0; m_right = 0; m_winner = 0; m_over = 0; m_blinking = 0; m_ticks = 0;
            if (rs) m_side = 0;
        end else if (m_over) begin
            if (fr) m_ticks++;
        end else if (m_blinking) begin
            if (fr) begin
                m_ticks++;
                if (m_ticks == BLINK_FRAMES) begin
                    m_blinking = 0;
                    m_ticks = 0;
                end
            end
        end else if (pl || pr) begin
            if (pl) m_left++; else m_right++;
            m_ticks = 0;
            if ((pl ? m_left : m_right) == WIN_SCORE) begin
                m_over = 1;
                m_winner = pl ? 0 : 1;
            end else begin
                m_blinking = 1;
                m_side = pl ? 0 : 1;
            end
        end
    endtask

    task automatic expected_pixel(input int row, input int col, output int sel, output int r,
                                  output int c, output logic [2:0] px);
        bit in_rows;
        in_rows = row >= DIGIT_Y && row < DIGIT_Y + DIGIT_H;
        sel = 0; r = 0; c = 0; px = 3'b000;
        if (in_rows && col >= LEFT_X && col < LEFT_X + DIGIT_W) begin
            sel = m_left; r = row - DIGIT_Y; c = col - LEFT_X;
            if (!side_hidden(0)) px = rom_pixel(4'(sel), 10'(r), 10'(c));
        end else if (in_rows && col >= RIGHT_X && col < RIGHT_X + DIGIT_W) begin
            sel = m_right; r = row - DIGIT_Y; c = col - RIGHT_X;
            if (!side_hidden(1)) px = rom_pixel(4'(sel), 10'(r), 10'(c));
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input bit fr, input bit pl, input bit pr, input bit cl,
                                  input bit rs, input int prow, input int pcol);
        int sel, r, c;
        logic [2:0] px, exp_rgb;
        @(negedge clk);
        frame_tick = fr; point_left = pl; point_right = pr; clear = cl; reset = rs;
        pix_row = 10'(prow); pix_col = 10'(pcol);
        @(posedge clk);
        #1;
        exp_rgb = rs ? 3'b000 : pending_rgb;
        model_update(fr, pl, pr, cl, rs);
        expected_pixel(rs ? 0 : prow, rs ? 0 : pcol, sel, r, c, px);
        pending_rgb = px;
        check_output("rgb", rgb, exp_rgb);
        check_output("digit_sel", digit_sel, sel);
        check_output("sprite_row", sprite_row, r);
        check_output("sprite_col", sprite_col, c);
        check_output("score_left", score_left, m_left);
        check_output("score_right", score_right, m_right);
        check_output("game_over", game_over, m_over);
        if (m_over) check_output("winner", winner, m_winner);
        else check_output("winner_idle", winner, 0);
    endtask

    function automatic int rand_row();
        return $urandom_range(38, 16);
    endfunction

    function automatic int rand_col();
        return ($urandom_range(1, 0) == 0) ? $urandom_range(294, 276) : $urandom_range(363, 345);
    endfunction

    // Ticks every other cycle so a full blink period ends well inside n = 70 cycles.
    task automatic run_frames(input int n, input bit noisy_points);
        bit pl, pr;
        for (int i = 0; i < n; i++) begin
            pl = noisy_points && i < 40 && ($urandom_range(7, 0) == 0);
            pr = noisy_points && i < 40 && ($urandom_range(7, 0) == 0);
            apply_stimulus(i % 2 == 1, pl, pr, 0, 0, rand_row(), rand_col());
        end
    endtask

    task automatic score_point(input bit left_side);
        apply_stimulus(0, left_side, !left_side, 0, 0, rand_row(), rand_col());
        run_frames(70, 0);
    endtask

    initial begin
        reset = 1'b0; frame_tick = 1'b0; point_left = 1'b0; point_right = 1'b0; clear = 1'b0;
        pix_row = '0; pix_col = '0;
        m_side = 0; pending_rgb = 3'b000;
        $display("[TB] start");

        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 1, rand_row(), rand_col());

        for (int row = 20; row <= 35; row++)
            for (int col = 280; col <= 290; col++) apply_stimulus(0, 0, 0, 0, 0, row, col);
        apply_stimulus(0, 0, 0, 0, 0, 19, 280);
        apply_stimulus(0, 0, 0, 0, 0, 20, 291);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);

        apply_stimulus(0, 1, 0, 0, 0, 25, 285);
        for (int i = 0; i < 70; i++)
            apply_stimulus(i % 2 == 1, 0, (i < 50) && (i % 5 == 0), 0, 0,
                           $urandom_range(35, 20), $urandom_range(290, 280));
        apply_stimulus(0, 0, 1, 0, 0, 30, 355);
        run_frames(70, 0);

        apply_stimulus(0, 0, 0, 1, 0, rand_row(), rand_col());
        apply_stimulus(0, 1, 1, 0, 0, rand_row(), rand_col());
        run_frames(70, 1);

        apply_stimulus(0, 0, 0, 1, 0, rand_row(), rand_col());
        for (int k = 0; k < 8; k++) score_point(0);
        apply_stimulus(0, 0, 1, 0, 0, 22, 350);
        apply_stimulus(0, 1, 0, 0, 0, 22, 351);
        for (int i = 0; i < 80; i++)
            apply_stimulus(1, i % 9 == 0, i % 7 == 0, 0, 0,
                           $urandom_range(35, 20), $urandom_range(359, 349));

        apply_stimulus(0, 1, 0, 1, 0, rand_row(), rand_col());
        apply_stimulus(0, 0, 0, 0, 0, rand_row(), rand_col());

        score_point(1); score_point(0); score_point(1); score_point(0);
        apply_stimulus(0, 1, 0, 0, 0, 28, 284);
        for (int i = 0; i < 20; i++) apply_stimulus(1, 0, 0, 0, 0, 28, 284);
        apply_stimulus(0, 0, 0, 0, 1, 28, 284);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 0, 0, 28, 284);

        for (int i = 0; i < 600; i++)
            apply_stimulus($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0,
                           $urandom_range(19, 0) == 0, $urandom_range(199, 0) == 0,
                           $urandom_range(399, 0) == 0, rand_row(), rand_col());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
